regfile_4r2w: RTL and testbench

- 32-entry x 64-bit general-purpose register file for the single-cycle processor datapath.
- Four independent combinational read ports and two synchronous write ports.
- Sits between instruction decode (register addresses) and the ALU/writeback stage.
- Register 0 is hardwired to zero.

---
 rtl/regfile_4r2w.sv | 74 +++++++
 tb/tb_regfile_4r2w.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_4r2w.sv
//------------------------------------------------------------------------------
// Module   : regfile_4r2w
// Brief    : 32 x 64-bit register file, four combinational read ports,
//            two synchronous write ports, register 0 hardwired to zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_4r2w #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_port1,
  input  logic [ADDR_WIDTH-1:0] read_port2,
  input  logic [ADDR_WIDTH-1:0] read_port3,
  input  logic [ADDR_WIDTH-1:0] read_port4,
  input  logic [ADDR_WIDTH-1:0] write_port1,
  input  logic [ADDR_WIDTH-1:0] write_port2,
  input  logic [DATA_WIDTH-1:0] write_data1,
  input  logic [DATA_WIDTH-1:0] write_data2,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] read_data3,
  output logic [DATA_WIDTH-1:0] read_data4
);

  localparam int              C_NUM_RD = 4;
  localparam [ADDR_WIDTH-1:0] C_ZERO   = '0;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] w_raddr [C_NUM_RD];
  logic [DATA_WIDTH-1:0] w_rdata [C_NUM_RD];

  // Port 2 is assigned last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write) begin
      if (write_port1 != C_ZERO) begin
        r_regs[write_port1] <= write_data1;
      end
      if (write_port2 != C_ZERO) begin
        r_regs[write_port2] <= write_data2;
      end
    end
  end

  assign w_raddr[0] = read_port1;
  assign w_raddr[1] = read_port2;
  assign w_raddr[2] = read_port3;
  assign w_raddr[3] = read_port4;

  generate
    for (genvar g = 0; g < C_NUM_RD; g++) begin : g_read
      assign w_rdata[g] = (read && (w_raddr[g] != C_ZERO)) ? r_regs[w_raddr[g]]
                                                           : '0;
    end
  endgenerate

  assign read_data1 = w_rdata[0];
  assign read_data2 = w_rdata[1];
  assign read_data3 = w_rdata[2];
  assign read_data4 = w_rdata[3];

endmodule

`default_nettype wire

// File: tb/tb_regfile_4r2w.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile_4r2w
// Brief    : Directed self-checking bench for regfile_4r2w with a read scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_4r2w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read_port1, read_port2, read_port3, read_port4;
  logic [4:0]  write_port1, write_port2;
  logic [63:0] write_data1, write_data2;
  logic        write, read;
  logic [63:0] read_data1, read_data2, read_data3, read_data4;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t q_exp[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  regfile_4r2w dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_port1  (read_port1),
    .read_port2  (read_port2),
    .read_port3  (read_port3),
    .read_port4  (read_port4),
    .write_port1 (write_port1),
    .write_port2 (write_port2),
    .write_data1 (write_data1),
    .write_data2 (write_data2),
    .write       (write),
    .read        (read),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .read_data3  (read_data3),
    .read_data4  (read_data4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive four read addresses and queue the values they must return.
  task automatic drive_reads(input string tag,
                             input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] a3, input logic [4:0] a4,
                             input logic [63:0] e1, input logic [63:0] e2,
                             input logic [63:0] e3, input logic [63:0] e4);
    exp_t e;
    read_port1 = a1; read_port2 = a2; read_port3 = a3; read_port4 = a4;
    e.tag = {tag, "_p1"}; e.val = e1; q_exp.push_back(e);
    e.tag = {tag, "_p2"}; e.val = e2; q_exp.push_back(e);
    e.tag = {tag, "_p3"}; e.val = e3; q_exp.push_back(e);
    e.tag = {tag, "_p4"}; e.val = e4; q_exp.push_back(e);
  endtask

  task automatic check_reads();
    exp_t        e;
    logic [63:0] obs;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (q_exp.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL scoreboard_empty observed=empty expected=entry");
        return;
      end
      e = q_exp.pop_front();
      case (k)
        0: obs = read_data1;
        1: obs = read_data2;
        2: obs = read_data3;
        default: obs = read_data4;
      endcase
      tests_run++;
      assert (obs === e.val) else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_write(input logic [4:0] a1, input logic [63:0] d1,
                          input logic [4:0] a2, input logic [63:0] d2);
    write = 1'b1;
    write_port1 = a1; write_data1 = d1;
    write_port2 = a2; write_data2 = d2;
    tick();
    write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; read = 1'b0;
    read_port1 = '0; read_port2 = '0; read_port3 = '0; read_port4 = '0;
    write_port1 = '0; write_port2 = '0; write_data1 = '0; write_data2 = '0;

    // Reset clears everything
    tick();
    rst_n = 1'b1;
    read = 1'b1;
    drive_reads("reset", 5'd0, 5'd5, 5'd17, 5'd31, 64'h0, 64'h0, 64'h0, 64'h0);
    check_reads();

    // Dual-port writes
    do_write(5'd10, 64'h0000_0000_1234_5678, 5'd15, 64'hDEAD_BEEF_0000_0001);
    do_write(5'd4,  64'h0000_0000_0000_00AA, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_reads("write", 5'd10, 5'd15, 5'd4, 5'd12,
                64'h0000_0000_1234_5678, 64'hDEAD_BEEF_0000_0001,
                64'h0000_0000_0000_00AA, 64'hFFFF_FFFF_FFFF_FFFF);
    check_reads();

    // All ports on one address
    drive_reads("same_rd", 5'd12, 5'd12, 5'd12, 5'd12,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check_reads();

    // Conflict: old value visible before the edge, port 2 wins after it
    write = 1'b1;
    write_port1 = 5'd2; write_data1 = 64'h1111;
    write_port2 = 5'd2; write_data2 = 64'h2222;
    drive_reads("pre_edge", 5'd2, 5'd10, 5'd15, 5'd0,
                64'h0, 64'h0000_0000_1234_5678, 64'hDEAD_BEEF_0000_0001, 64'h0);
    check_reads();
    @(posedge clk);
    #1;
    write = 1'b0;
    drive_reads("conflict", 5'd2, 5'd4, 5'd12, 5'd10,
                64'h2222, 64'h0000_0000_0000_00AA,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5678);
    check_reads();

    // Read disable forces zero, re-enable restores without an edge
    read = 1'b0;
    drive_reads("rd_off", 5'd10, 5'd15, 5'd4, 5'd12, 64'h0, 64'h0, 64'h0, 64'h0);
    check_reads();
    read = 1'b1;
    drive_reads("rd_on", 5'd10, 5'd15, 5'd4, 5'd12,
                64'h0000_0000_1234_5678, 64'hDEAD_BEEF_0000_0001,
                64'h0000_0000_0000_00AA, 64'hFFFF_FFFF_FFFF_FFFF);
    check_reads();

    // Register 0 ignores writes
    do_write(5'd0, 64'h55, 5'd0, 64'h55);
    drive_reads("reg0", 5'd0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    check_reads();

    // Disabled write with garbage and X inputs leaves state alone
    write = 1'b0;
    write_port1 = 5'd10; write_data1 = 64'hBAD0_BAD0_BAD0_BAD0;
    write_port2 = 5'bx;  write_data2 = 64'bx;
    tick();
    tick();
    drive_reads("wr_off", 5'd10, 5'd15, 5'd4, 5'd2,
                64'h0000_0000_1234_5678, 64'hDEAD_BEEF_0000_0001,
                64'h0000_0000_0000_00AA, 64'h2222);
    check_reads();

    // Reset overrides a simultaneous write
    rst_n = 1'b0;
    write = 1'b1;
    write_port1 = 5'd10; write_data1 = 64'h99;
    write_port2 = 5'd31; write_data2 = 64'h77;
    tick();
    rst_n = 1'b1;
    write = 1'b0;
    drive_reads("rst_wr", 5'd10, 5'd15, 5'd31, 5'd12, 64'h0, 64'h0, 64'h0, 64'h0);
    check_reads();

    tests_run++;
    assert (q_exp.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
